dmem_arbiter: RTL and testbench

Two-port arbiter and byte-write controller in front of the 64-word, 32-bit data memory (synchronous write, asynchronous read). It shares the single memory port between the pipeline MEM stage (port 0) and the debug/program-loader port (port 1). Byte-strobed stores are merged into the addressed word in one cycle, using the memory's asynchronous read. Each accepted request returns a registered response one cycle later, with an error flag for illegal addresses.

---
 rtl/dmem_arb_pkg.sv | 32 +++
 rtl/dmem_arb_pick.sv | 32 +++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types, constants and helpers for the data-memory arbiter.
//   port_idx_t     : index of one of the two requesting ports
//   NUM_PORTS      : number of requesting ports (2)
//   DMEM_WORDS_DEF : default memory depth in 32-bit words
//   be2mask()      : expands 4 byte enables into a 32-bit byte mask
//   addr_legal()   : word-aligned and inside the memory
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef logic [0:0] port_idx_t;

    localparam int NUM_PORTS      = 2;
    localparam int DMEM_WORDS_DEF = 64;

    function automatic logic [31:0] be2mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    // The limit is widened to 34 bits so 4*words cannot wrap for large depths.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
        logic [33:0] lim;
        lim = 34'(words) << 2;
        return (addr[1:0] == 2'b00) && (34'(addr) < lim);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational two-way picker producing a one-hot (or zero) grant.
//   req_i   [1:0] : per-port request
//   pref_i        : port that wins when both request
//   force_i       : on contention, port 1 wins regardless of pref_i
//   gnt_o   [1:0] : one-hot grant, zero when nobody requests
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  port_idx_t            pref_i,
    input  logic                 force_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i == 2'b11) begin
            if (force_i || (pref_i == 1'b1)) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end else begin
            // Zero or one requester: pass the request straight through.
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single port of a 32-bit data memory (sync write, async read)
// between the MEM stage (port 0) and the debug/loader port (port 1).
// Byte-strobed stores are merged into the addressed word in one cycle; every
// grant produces a registered response one cycle later.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin arbitration (pointer flips after each grant)
//   undefined : port 0 fixed priority with a port 1 starvation counter
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_i/we_i [1:0]      : per-port request / write(1) read(0)
//   be_i       [1:0][3:0] : per-port byte enables (writes only)
//   addr_i     [1:0][31:0]: per-port byte address
//   wdata_i    [1:0][31:0]: per-port write data
//   gnt_o      [1:0]      : combinational grant, one-hot or zero
//   rvalid_o   [1:0]      : registered response strobe
//   rdata_o    [31:0]     : registered read data (0 for writes/errors)
//   err_o                 : registered illegal-address flag
//   mem_we/mem_addr/mem_wdata : memory write enable, byte address, merged word
//   mem_rdata             : asynchronous memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned DMEM_WORDS   = DMEM_WORDS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]        we_i,
    input  logic [NUM_PORTS-1:0][3:0]   be_i,
    input  logic [NUM_PORTS-1:0][31:0]  addr_i,
    input  logic [NUM_PORTS-1:0][31:0]  wdata_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic [NUM_PORTS-1:0]        rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic                        err_o,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata
);

    logic [NUM_PORTS-1:0] pick_gnt;
    port_idx_t            pref;
    logic                 force_p1;

    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    logic [31:0]          rdata_q,  rdata_d;
    logic                 err_q,    err_d;

    port_idx_t            sel;
    logic                 any_gnt;
    logic                 legal;
    logic                 wr;
    logic [31:0]          mask;

`ifdef DMEM_ARB_RR_EN
    port_idx_t ptr_q, ptr_d;

    assign pref     = ptr_q;
    assign force_p1 = 1'b0;

    // After any grant the other port becomes preferred.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign pref     = 1'b0;
    // The counter never passes LIMIT-1: at that value port 1 is granted on
    // the next cycle it requests, contended or not, which clears it.
    assign force_p1 = (starve_cnt_q == CNT_W'(STARVE_LIMIT - 1));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req_i[1] || gnt_o[1]) begin
            starve_cnt_d = '0;
        end else begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    dmem_arb_pick u_pick (
        .req_i   (req_i),
        .pref_i  (pref),
        .force_i (force_p1),
        .gnt_o   (pick_gnt)
    );

    // Grants (and hence all memory drive) are suppressed while in reset.
    assign gnt_o   = rst_n ? pick_gnt : '0;
    assign any_gnt = |gnt_o;
    assign sel     = gnt_o[1];

    assign legal = addr_legal(addr_i[sel], DMEM_WORDS);
    assign wr    = any_gnt && we_i[sel] && legal;
    assign mask  = be2mask(be_i[sel]);

    assign mem_addr  = any_gnt ? addr_i[sel] : 32'h0;
    assign mem_we    = wr;
    assign mem_wdata = wr ? ((mem_rdata & ~mask) | (wdata_i[sel] & mask)) : 32'h0;

    always_comb begin
        rvalid_d = gnt_o;
        err_d    = any_gnt && !legal;
        rdata_d  = 32'h0;
        if (any_gnt && legal && !we_i[sel]) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 64x32 memory attached.
// Expected responses are queued at grant time and popped one cycle later.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [1:0][3:0]   be_i;
    logic [1:0][31:0]  addr_i;
    logic [1:0][31:0]  wdata_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: sync write, async read, plus a preload path.
    logic [31:0] mem [64];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_idx] <= pl_dat;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q [$];
    logic [31:0] ref_mem [64];
    int          nvec  = 0;
    int          nfail = 0;

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] v;
        v = 32'(i) * 32'h01010101;
        if (i == 3) v = 32'hDEADBEEF;
        if (i == 5) v = 32'h11223344;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check the response owed from the previous cycle, check the
    // grant and memory drive, queue the response owed next cycle.
    task automatic step(input logic [1:0] exp_gnt);
        rsp_t        r;
        int          p;
        logic [31:0] a;
        logic [31:0] m;
        logic [31:0] w;
        logic        lg;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("rvalid", 32'(rvalid_o), 32'(r.port));
            chk("rdata",  rdata_o, r.rdata);
            chk("err",    32'(err_o), 32'(r.err));
        end else begin
            chk("rvalid_idle", 32'(rvalid_o), 32'h0);
        end
        chk("gnt", 32'(gnt_o), 32'(exp_gnt));
        if (exp_gnt != 2'b00) begin
            p  = exp_gnt[1] ? 1 : 0;
            a  = addr_i[p];
            lg = (a[1:0] == 2'b00) && (a < 32'd256);
            chk("mem_addr", mem_addr, a);
            r.port = exp_gnt;
            if (!lg) begin
                r.rdata = 32'h0;
                r.err   = 1'b1;
                chk("mem_we_illegal", 32'(mem_we), 32'h0);
            end else if (we_i[p]) begin
                for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be_i[p][b]}};
                w = (ref_mem[a[7:2]] & ~m) | (wdata_i[p] & m);
                chk("mem_we_wr", 32'(mem_we), 32'h1);
                chk("mem_wdata", mem_wdata, w);
                ref_mem[a[7:2]] = w;
                r.rdata = 32'h0;
                r.err   = 1'b0;
            end else begin
                chk("mem_we_rd", 32'(mem_we), 32'h0);
                r.rdata = ref_mem[a[7:2]];
                r.err   = 1'b0;
            end
            exp_q.push_back(r);
        end else begin
            chk("mem_we_idle",   32'(mem_we), 32'h0);
            chk("mem_addr_idle", mem_addr, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] cexp [9];

    initial begin
        rst_n   = 1'b0;
        req_i   = '0;
        we_i    = '0;
        be_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
        pl_we   = 1'b0;
        pl_idx  = '0;
        pl_dat  = '0;

        // Preload the memory while the arbiter is held in reset.
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            pl_we      = 1'b1;
            pl_idx     = 6'(i);
            pl_dat     = init_val(i);
            ref_mem[i] = init_val(i);
            @(posedge clk);
            #1;
        end
        pl_we = 1'b0;

        // Reset state.
        chk("rst_gnt",    32'(gnt_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata",  rdata_o, 32'h0);
        chk("rst_err",    32'(err_o), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_maddr",  mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Single read of word 3 by port 0.
        req_i[0] = 1'b1; we_i[0] = 1'b0; be_i[0] = 4'h0; addr_i[0] = 32'h0C;
        step(2'b01);
        req_i[0] = 1'b0;
        step(2'b00);

        // Byte write to word 5 by port 1, then read-after-write by port 0.
        req_i[1] = 1'b1; we_i[1] = 1'b1; be_i[1] = 4'b0010;
        addr_i[1] = 32'h14; wdata_i[1] = 32'hAABBCCDD;
        step(2'b10);
        req_i[1] = 1'b0;
        req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 32'h14;
        step(2'b01);
        req_i[0] = 1'b0;
        step(2'b00);
        chk("word5_merged", mem[5], 32'h1122CC44);

        // Zero byte enables: legal write, word unchanged.
        req_i[0] = 1'b1; we_i[0] = 1'b1; be_i[0] = 4'h0;
        addr_i[0] = 32'h0C; wdata_i[0] = 32'h0;
        step(2'b01);
        req_i[0] = 1'b0;
        step(2'b00);
        chk("word3_be0", mem[3], 32'hDEADBEEF);

        // Illegal addresses: misaligned, then past the end.
        req_i[0] = 1'b1; we_i[0] = 1'b1; be_i[0] = 4'hF;
        addr_i[0] = 32'h102; wdata_i[0] = 32'h12345678;
        step(2'b01);
        addr_i[0] = 32'h100;
        step(2'b01);
        req_i[0] = 1'b0;
        step(2'b00);
        chk("word0_untouched", mem[0], init_val(0));

        // Continuous contention from a fresh reset.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef DMEM_ARB_RR_EN
        cexp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
        cexp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif
        req_i = 2'b11; we_i = 2'b00;
        addr_i[0] = 32'h0C; addr_i[1] = 32'h14;
        for (int i = 0; i < 9; i++) step(cexp[i]);
        req_i = 2'b00;
        step(2'b00);

        // Reset asserted while a read response is on the outputs.
        req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 32'h0C;
        step(2'b01);
        rst_n = 1'b0;
        #1;
        chk("rstmid_rvalid", 32'(rvalid_o), 32'h0);
        chk("rstmid_rdata",  rdata_o, 32'h0);
        chk("rstmid_err",    32'(err_o), 32'h0);
        chk("rstmid_gnt",    32'(gnt_o), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b01);
        req_i[0] = 1'b0;
        step(2'b00);
        step(2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
